// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encoding, bus direction
// codes and the byte-offset width of the word-addressed bus.
// Imported by mem_responder and mem_word_array.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The wr pin is high for reads.
  localparam logic WR_READ  = 1'b1;
  localparam logic WR_WRITE = 1'b0;

  // Byte offset inside a 32-bit word; the word index starts above it.
  localparam int BYTE_OFF_W = 2;
  localparam int LANES      = 1 << BYTE_OFF_W;

endpackage

// File: rtl/mem_word_array.sv
// 2**AW x 32 word array with a byte-enable write port and a registered read port.
// Latency: one edge; on an enabled edge rdata captures the (merged) word.
// Backpressure: none; the caller issues at most one access per enabled edge.
module mem_word_array
  import mem_responder_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    idx,
  input  logic [31:0]      wdata,
  input  logic [LANES-1:0] be,
  output logic [31:0]      rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] merged;

  // Old word with enabled lanes replaced; equals the old word for reads or be = 0.
  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < LANES; i++) begin
      if (we && be[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Storage is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= merged;
    end
  end

  // Response word: read data or write-through echo, held until the next access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= merged;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request, waits WAIT_CYCLES, then reads or byte-writes a word.
// Latency: rvalid is sampled high WAIT_CYCLES+1 edges after the accept edge (one-cycle pulse).
// Backpressure: ack is low outside IDLE; optional misaligned check under MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        ack,
  input  logic [31:0] addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        rvalid
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        commit;

  // Request captured at accept, used once the wait states have elapsed.
  logic [AW-1:0] lat_idx;
  logic          lat_wr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;

  // Operands presented to the array on the commit edge.
  logic [AW-1:0] src_idx;
  logic          src_wr;
  logic [31:0]   src_wdata;
  logic [3:0]    src_be;
  logic          src_mis;
  logic          arr_en;
  logic          arr_we;

  logic          unused_bits;

  assign ack    = (state == IDLE);
  assign accept = req && ack;
  assign rvalid = (state == RESP);

  // With zero wait states the commit happens on the accept edge, so the live bus is used.
  assign src_idx   = (state == IDLE) ? addr[AW+BYTE_OFF_W-1:BYTE_OFF_W] : lat_idx;
  assign src_wr    = (state == IDLE) ? wr    : lat_wr;
  assign src_wdata = (state == IDLE) ? wdata : lat_wdata;
  assign src_be    = (state == IDLE) ? be    : lat_be;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic lat_mis;
  logic err_q;

  assign src_mis = (state == IDLE) ? (addr[BYTE_OFF_W-1:0] != '0) : lat_mis;
  assign err     = rvalid && err_q;

  // Misalignment is remembered per request and only shown during its response cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_mis <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) lat_mis <= (addr[BYTE_OFF_W-1:0] != '0);
      if (commit) err_q   <= src_mis;
    end
  end
`else
  assign src_mis = 1'b0;
`endif

  // rst gates the commit so a request seen during reset can never touch the array.
  assign arr_en = commit && rst;
  assign arr_we = arr_en && (src_wr == WR_WRITE) && !src_mis;

  assign unused_bits = ^{addr[31:AW+BYTE_OFF_W], addr[BYTE_OFF_W-1:0]};

  // Next-state logic: accept in IDLE, count down in WAIT, single response cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, wait counter and request latch; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_idx   <= '0;
      lat_wr    <= WR_READ;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_idx   <= addr[AW+BYTE_OFF_W-1:BYTE_OFF_W];
        lat_wr    <= wr;
        lat_wdata <= wdata;
        lat_be    <= be;
      end
    end
  end

  mem_word_array #(
    .AW (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (arr_en),
    .we    (arr_we),
    .idx   (src_idx),
    .wdata (src_wdata),
    .be    (src_be),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance 0 with two wait states, instance 1 with none.
// Expected responses are pushed to a per-instance queue at request time and popped on rvalid.
// The alignment check is exercised when MEM_RESPONDER_ALIGN_CHECK_EN is defined.
module tb_mem_responder;

  localparam int AW = 10;
  localparam int W0 = 2;
  localparam int W1 = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [2];
  logic        ack    [2];
  logic [31:0] addr   [2];
  logic        wr     [2];
  logic [31:0] wdata  [2];
  logic [3:0]  be     [2];
  logic [31:0] rdata  [2];
  logic        rvalid [2];
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic        err    [2];
`endif

  int total = 0;
  int bad   = 0;

  exp_t        sbq0 [$];
  exp_t        sbq1 [$];
  logic [31:0] mdl  [2][1 << AW];

  always #5 clk = ~clk;

  mem_responder #(.AW(AW), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .ack(ack[0]), .addr(addr[0]), .wr(wr[0]),
    .wdata(wdata[0]), .be(be[0]), .rdata(rdata[0]), .rvalid(rvalid[0])
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    , .err(err[0])
`endif
  );

  mem_responder #(.AW(AW), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .ack(ack[1]), .addr(addr[1]), .wr(wr[1]),
    .wdata(wdata[1]), .be(be[1]), .rdata(rdata[1]), .rvalid(rvalid[1])
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    , .err(err[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Scoreboard side: every response is matched against the oldest expectation.
  task automatic check_resp(input int d);
    exp_t e;
    int   n;
    n = (d == 0) ? sbq0.size() : sbq1.size();
    total++;
    assert (n > 0) else begin
      bad++;
      $error("FAIL unexpected_rvalid_%0d observed=response expected=none", d);
    end
    if (n > 0) begin
      e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
      chk($sformatf("rdata_%0d", d), rdata[d], e.data);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      chk($sformatf("err_%0d", d), 32'(err[d]), 32'(e.err));
`endif
    end
  endtask

  always @(negedge clk) begin
    if (rvalid[0] === 1'b1) check_resp(0);
    if (rvalid[1] === 1'b1) check_resp(1);
  end

  // One complete transaction; starts and ends on a falling edge.
  task automatic txn(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [3:0] b, input string tag);
    int   g;
    int   k;
    int   ix;
    int   wc;
    logic mis;
    exp_t e;
    wc  = (d == 0) ? W0 : W1;
    ix  = int'((a >> 2) & 32'((1 << AW) - 1));
    mis = 1'b0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`endif
    g = 0;
    while (ack[d] !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_ack_ready"}, 32'(ack[d]), 32'd1);
    req[d] = 1'b1; addr[d] = a; wr[d] = w; wdata[d] = wd; be[d] = b;
    e.err  = mis;
    e.data = mdl[d][ix];
    if (w == 1'b0 && !mis) begin
      e.data     = merge(mdl[d][ix], wd, b);
      mdl[d][ix] = e.data;
    end
    if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
    @(posedge clk);
    #1;
    req[d] = 1'b0;
    chk({tag, "_ack_fall"}, 32'(ack[d]), 32'd0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rvalid[d] !== 1'b1 && k < 40);
    chk({tag, "_latency"}, 32'(k), 32'(wc + 1));
    chk({tag, "_ack_in_resp"}, 32'(ack[d]), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(rvalid[d]), 32'd0);
    chk({tag, "_ack_back"}, 32'(ack[d]), 32'd1);
    chk({tag, "_rdata_hold"}, rdata[d], e.data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; addr[d] = '0; wr[d] = 1'b1; wdata[d] = '0; be[d] = '0;
    end
    repeat (3) @(negedge clk);
    // A request during reset must be ignored.
    req[0] = 1'b1; wr[0] = 1'b0; be[0] = 4'hF; wdata[0] = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("rst_ack", 32'(ack[0]), 32'd1);
    chk("rst_rvalid", 32'(rvalid[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    req[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_rvalid", 32'(rvalid[0]), 32'd0);

    // Full word write, read-back and address wrap (upper bits ignored).
    txn(0, 32'h10, 1'b0, 32'hDEADBEEF, 4'hF, "wr_full");
    txn(0, 32'h10, 1'b1, 32'h0, 4'h0, "rd_10");
    txn(0, 32'h10 + (4 << AW), 1'b1, 32'h0, 4'h0, "rd_wrap");
    txn(0, 32'h8000_0010, 1'b1, 32'h0, 4'h0, "rd_upper");
    // Byte-masked write, then be = 0 leaves the word intact.
    txn(0, 32'h10, 1'b0, 32'h11223344, 4'b0101, "wr_mask");
    txn(0, 32'h10, 1'b1, 32'h0, 4'h0, "rd_mask");
    txn(0, 32'h10, 1'b0, 32'hFFFFFFFF, 4'h0, "wr_be0");
    txn(0, 32'h10, 1'b1, 32'h0, 4'h0, "rd_be0");
    // Highest index and a lane pattern.
    txn(0, 32'hFFC, 1'b0, 32'h0102_0304, 4'b1010, "wr_top");
    txn(0, 32'hFFC, 1'b1, 32'h0, 4'h0, "rd_top");

    // Reset during WAIT: the write to 0x20 must be dropped with no response.
    txn(0, 32'h20, 1'b0, 32'hCAFEF00D, 4'hF, "wr_20");
    req[0] = 1'b1; addr[0] = 32'h20; wr[0] = 1'b0; wdata[0] = 32'h0; be[0] = 4'hF;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    chk("abort_in_wait", 32'(ack[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ack", 32'(ack[0]), 32'd1);
    chk("abort_rdata", rdata[0], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rvalid", 32'(rvalid[0]), 32'd0);
    end
    txn(0, 32'h20, 1'b1, 32'h0, 4'h0, "rd_20");

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    // Misaligned write: response with err, array untouched.
    txn(0, 32'h13, 1'b0, 32'h5555_5555, 4'hF, "wr_misal");
    txn(0, 32'h10, 1'b1, 32'h0, 4'h0, "rd_after_misal");
`endif

    // Zero wait states, back-to-back requests.
    txn(1, 32'h0, 1'b0, 32'hA5A5_0001, 4'hF, "z_wr0");
    txn(1, 32'h4, 1'b0, 32'h5A5A_0002, 4'hF, "z_wr4");
    txn(1, 32'h0, 1'b1, 32'h0, 4'h0, "z_rd0");
    txn(1, 32'h4, 1'b1, 32'h0, 4'h0, "z_rd4");
    txn(1, 32'h4, 1'b0, 32'hFFEE_DDCC, 4'b0011, "z_wrmask");
    txn(1, 32'h4, 1'b1, 32'h0, 4'h0, "z_rdmask");

    repeat (3) @(negedge clk);
    chk("sb_empty0", 32'(sbq0.size()), 32'd0);
    chk("sb_empty1", 32'(sbq1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
